// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Run/stall/flush sequencer for the 5-stage RV32I pipeline. It sits beside the
// opcode decoder and owns the processor life cycle:
// IDLE -> RUN -> DRAIN -> DONE, or FAULT.
// Stage enables and flushes are Mealy outputs, so a stall or flush takes
// effect in the same cycle as the condition that causes it.
// Optional feature: define PIPELINE_SEQUENCER_PERF_CNT_EN to add saturating
// cycle/stall/flush performance counters (cycle_cnt, stall_cnt, flush_cnt).
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic       endProcess,
  input  logic       error,
  input  logic       memRead_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rs1_id,
  input  logic       use_rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs2_id,
  input  logic       redirect_ex,
  input  logic       mem_busy,
  output logic       pc_clear,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       cu_enable,
  output logic       running,
  output logic       done,
  output logic       fault
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Drain counter is wide enough to hold DRAIN_CYCLES-1 (at least one bit).
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [DW-1:0] cnt_r;
  logic [DW-1:0] cnt_nxt_s;
  logic          load_use_s;

  // Load in EX feeding a register the ID instruction actually reads; x0 never hazards.
  assign load_use_s = memRead_ex && (rd_ex != 5'd0) &&
                      ((use_rs1_id && (rs1_id == rd_ex)) ||
                       (use_rs2_id && (rs2_id == rd_ex)));

  // Next-state decode and Mealy stage controls, RUN cases in strict priority order.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pc_clear    = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    cu_enable   = 1'b0;
    running     = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        done = (state_r == ST_DONE);
        if (start) begin
          state_nxt_s = ST_RUN;
          pc_clear    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        running = 1'b1;
        if (mem_busy) begin
          // Full freeze: every stage holds, pending redirect/hazard is re-seen later.
          state_nxt_s = ST_RUN;
        end else if (error) begin
          // Illegal opcode wins even on a wrong path; the compiler must pad.
          state_nxt_s = ST_FAULT;
        end else if (redirect_ex) begin
          // Squash the wrong-path IF and ID instructions; their status is ignored.
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          cu_enable  = 1'b1;
        end else if (load_use_s) begin
          // Hold PC and IF/ID, insert one bubble into ID/EX.
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
        end else if (endProcess) begin
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = DRAIN_LOAD;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          cu_enable   = 1'b1;
        end else begin
          pc_en     = 1'b1;
          ifid_en   = 1'b1;
          idex_en   = 1'b1;
          exmem_en  = 1'b1;
          cu_enable = 1'b1;
        end
      end
      ST_DRAIN: begin
        running = 1'b1;
        if (mem_busy) begin
          // Freeze and hold the drain count until memory is ready.
          cnt_nxt_s = cnt_r;
        end else begin
          // Feed NOPs into IF/ID while the in-flight instructions retire.
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          if (cnt_r == {DW{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            cnt_nxt_s = cnt_r - DW'(1'b1);
          end
        end
      end
      ST_FAULT: begin
        fault       = 1'b1;
        state_nxt_s = ST_FAULT;
      end
      default: begin
        // Corrupted state register: park safely until reset.
        fault       = 1'b1;
        state_nxt_s = ST_FAULT;
      end
    endcase
  end

  // Life-cycle state and drain counter, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_r <= ST_IDLE;
      cnt_r   <= {DW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
  logic enter_run_s;
  logic busy_s;
  logic stall_evt_s;
  logic flush_evt_s;

  // Counter events, matching the RUN priority so overridden cases are not counted.
  always_comb begin
    busy_s      = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    enter_run_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start;
    stall_evt_s = (busy_s && mem_busy) ||
                  ((state_r == ST_RUN) && !mem_busy && !error && !redirect_ex && load_use_s);
    flush_evt_s = (state_r == ST_RUN) && !mem_busy && !error && redirect_ex;
  end

  // Saturating performance counters, cleared on reset and on every new run.
  always_ff @(posedge clk) begin
    if (!rstN || enter_run_s) begin
      cycle_cnt <= {CNT_W{1'b0}};
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (busy_s && (cycle_cnt != {CNT_W{1'b1}})) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1'b1);
      end else begin
        cycle_cnt <= cycle_cnt;
      end
      if (stall_evt_s && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1'b1);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush_evt_s && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1'b1);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
// Cycle-by-cycle scoreboard for pipeline_sequencer. Each cycle the expected
// output vector is pushed when the inputs are driven and popped/compared once
// the Mealy outputs have settled. Counter checks are built only when
// PIPELINE_SEQUENCER_PERF_CNT_EN is defined.
module tb_pipeline_sequencer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic       endProcess;
  logic       error;
  logic       memRead_ex;
  logic [4:0] rd_ex;
  logic [4:0] rs1_id;
  logic       use_rs1_id;
  logic [4:0] rs2_id;
  logic       use_rs2_id;
  logic       redirect_ex;
  logic       mem_busy;
  logic       pc_clear, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, cu_enable, running, done, fault;
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
  logic [3:0] cycle_cnt, stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Output vector: {pc_clear, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  //                 exmem_en, cu_enable, running, done, fault}
  logic [10:0] outs;
  assign outs = {pc_clear, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                 exmem_en, cu_enable, running, done, fault};

  localparam logic [10:0] P_IDLE   = 11'b000_0000_0000;
  localparam logic [10:0] P_START  = 11'b100_1010_0000;
  localparam logic [10:0] P_STARTD = 11'b100_1010_0010;
  localparam logic [10:0] P_RUN    = 11'b011_0101_1100;
  localparam logic [10:0] P_FRZ    = 11'b000_0000_0100;
  localparam logic [10:0] P_RDR    = 11'b011_1111_1100;
  localparam logic [10:0] P_LU     = 11'b000_0111_0100;
  localparam logic [10:0] P_DRN    = 11'b000_1101_0100;
  localparam logic [10:0] P_DONE   = 11'b000_0000_0010;
  localparam logic [10:0] P_FLT    = 11'b000_0000_0001;
  localparam logic [10:0] M_ALL    = 11'b111_1111_1111;
  localparam logic [10:0] M_ENDP   = 11'b110_1111_0111;  // ifid_en, cu_enable free
  localparam logic [10:0] M_DRN    = 11'b110_1111_1111;  // ifid_en free

  typedef struct {
    string       tag;
    logic [10:0] e;
    logic [10:0] m;
  } exp_t;
  exp_t sb[$];

  pipeline_sequencer #(
    .DRAIN_CYCLES(4)
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rstN(rstN), .start(start), .endProcess(endProcess), .error(error),
    .memRead_ex(memRead_ex), .rd_ex(rd_ex), .rs1_id(rs1_id), .use_rs1_id(use_rs1_id),
    .rs2_id(rs2_id), .use_rs2_id(use_rs2_id), .redirect_ex(redirect_ex),
    .mem_busy(mem_busy), .pc_clear(pc_clear), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .cu_enable(cu_enable), .running(running), .done(done),
    .fault(fault)
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
    ,
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    start = 1'b0; endProcess = 1'b0; error = 1'b0; memRead_ex = 1'b0;
    rd_ex = 5'd0; rs1_id = 5'd0; use_rs1_id = 1'b0; rs2_id = 5'd0;
    use_rs2_id = 1'b0; redirect_ex = 1'b0; mem_busy = 1'b0;
  endtask

  // Inputs are already driven at this negedge: push expectation, settle, compare.
  task automatic cyc(input string tag, input logic [10:0] e, input logic [10:0] m);
    exp_t x;
    exp_t y;
    x.tag = tag; x.e = e; x.m = m;
    sb.push_back(x);
    #2;
    y = sb.pop_front();
    chk(y.tag, {21'd0, outs & y.m}, {21'd0, y.e & y.m});
    @(negedge clk);
  endtask

  task automatic set_lu(input logic [4:0] r);
    memRead_ex = 1'b1; rd_ex = r; rs2_id = r; use_rs2_id = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    cyc("reset", P_IDLE, M_ALL);
    rstN = 1'b1;

    // T1: start pulse
    cyc("idle", P_IDLE, M_ALL);
    start = 1'b1; cyc("t1_start", P_START, M_ALL);
    start = 1'b0; cyc("t1_run", P_RUN, M_ALL);

    // T2: load-use hazards and non-hazards
    set_lu(5'd5); cyc("t2_lu_rs2", P_LU, M_ALL);
    clr_in(); cyc("t2_after", P_RUN, M_ALL);
    memRead_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; use_rs1_id = 1'b1;
    cyc("t2_lu_rs1", P_LU, M_ALL);
    use_rs1_id = 1'b0; cyc("t2_nouse", P_RUN, M_ALL);
    rd_ex = 5'd0; rs1_id = 5'd0; use_rs1_id = 1'b1; rs2_id = 5'd0; use_rs2_id = 1'b1;
    cyc("t2_x0", P_RUN, M_ALL);
    clr_in(); rd_ex = 5'd9; rs2_id = 5'd9; use_rs2_id = 1'b1;
    cyc("t2_noload", P_RUN, M_ALL);

    // T3: redirect beats load-use and endProcess
    clr_in(); redirect_ex = 1'b1; endProcess = 1'b1;
    memRead_ex = 1'b1; rd_ex = 5'd3; rs1_id = 5'd3; use_rs1_id = 1'b1;
    cyc("t3_redir", P_RDR, M_ALL);
    clr_in(); cyc("t3_stay", P_RUN, M_ALL);

    // mem_busy freezes everything, even error/redirect/end
    mem_busy = 1'b1; redirect_ex = 1'b1; error = 1'b1; endProcess = 1'b1;
    cyc("busy_frz1", P_FRZ, M_ALL);
    cyc("busy_frz2", P_FRZ, M_ALL);
    clr_in(); cyc("busy_stay", P_RUN, M_ALL);
    start = 1'b1; cyc("run_start", P_RUN, M_ALL);
    start = 1'b0;

    // T4: drain of 4 cycles, redirect/start ignored while draining
    endProcess = 1'b1; cyc("t4_endp", P_DRN, M_ENDP);
    clr_in(); cyc("t4_d1", P_DRN, M_DRN);
    redirect_ex = 1'b1; start = 1'b1; cyc("t4_d2", P_DRN, M_DRN);
    clr_in(); cyc("t4_d3", P_DRN, M_DRN);
    cyc("t4_d4", P_DRN, M_DRN);
    cyc("t4_done", P_DONE, M_ALL);
    cyc("t4_done_hold", P_DONE, M_ALL);
    start = 1'b1; cyc("t4_restart", P_STARTD, M_ALL);
    clr_in(); cyc("t4b_run", P_RUN, M_ALL);
    endProcess = 1'b1; cyc("t4b_endp", P_DRN, M_ENDP);
    clr_in(); cyc("t4b_d1", P_DRN, M_DRN);
    cyc("t4b_d2", P_DRN, M_DRN);
    mem_busy = 1'b1; cyc("t4b_b1", P_FRZ, M_ALL);
    cyc("t4b_b2", P_FRZ, M_ALL);
    clr_in(); cyc("t4b_d3", P_DRN, M_DRN);
    cyc("t4b_d4", P_DRN, M_DRN);
    cyc("t4b_done", P_DONE, M_ALL);

    // T5: error (on a redirect cycle) faults; only reset leaves FAULT
    start = 1'b1; cyc("t5_start", P_STARTD, M_ALL);
    clr_in(); cyc("t5_run", P_RUN, M_ALL);
    error = 1'b1; redirect_ex = 1'b1; cyc("t5_err", P_FRZ, M_ALL);
    clr_in(); cyc("t5_fault", P_FLT, M_ALL);
    start = 1'b1; cyc("t5_flt_start", P_FLT, M_ALL);
    start = 1'b0; cyc("t5_flt_hold", P_FLT, M_ALL);
    rstN = 1'b0; cyc("t5_rst", P_FLT, M_ALL);
    rstN = 1'b1; cyc("t5_idle", P_IDLE, M_ALL);

    // reset in the middle of a run returns to IDLE without pc_clear
    start = 1'b1; cyc("mr_start", P_START, M_ALL);
    start = 1'b0; cyc("mr_run", P_RUN, M_ALL);
    rstN = 1'b0; cyc("mr_rst", P_RUN, M_ALL);
    rstN = 1'b1; cyc("mr_idle", P_IDLE, M_ALL);

    // T6: 10-cycle run with 2 load-use stalls and 1 redirect
    start = 1'b1; cyc("t6_start", P_START, M_ALL);
    clr_in(); cyc("t6_c1", P_RUN, M_ALL);
    set_lu(5'd4); cyc("t6_lu1", P_LU, M_ALL);
    clr_in(); cyc("t6_c3", P_RUN, M_ALL);
    set_lu(5'd12); cyc("t6_lu2", P_LU, M_ALL);
    clr_in(); cyc("t6_c5", P_RUN, M_ALL);
    redirect_ex = 1'b1; cyc("t6_rdr", P_RDR, M_ALL);
    clr_in();
    for (int i = 0; i < 4; i++) cyc("t6_tail", P_RUN, M_ALL);
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
    chk("t6_cycle", {28'd0, cycle_cnt}, 32'd10);
    chk("t6_stall", {28'd0, stall_cnt}, 32'd2);
    chk("t6_flush", {28'd0, flush_cnt}, 32'd1);
`endif
    for (int i = 0; i < 6; i++) cyc("t6_more", P_RUN, M_ALL);
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
    chk("t6_sat", {28'd0, cycle_cnt}, 32'd15);
    chk("t6_stall2", {28'd0, stall_cnt}, 32'd2);
`endif
    rstN = 1'b0; cyc("end_rst", P_RUN, M_ALL);
    rstN = 1'b1; cyc("end_idle", P_IDLE, M_ALL);
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
    chk("rst_cycle", {28'd0, cycle_cnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
